// File: rtl/clk_ratio_gen.sv
// ============================================================================
// Module   : clk_ratio_gen
// Brief    : Registered divide-by-N slow-clock generator with a ready/valid
//            ratio port; new ratios take effect only at period boundaries.
//            Optional macro CLK_RATIO_GEN_STATS_EN adds the slow_count counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_ratio_gen #(
  parameter int unsigned DEFAULT_RATIO = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             fastclk,
  input  logic             reset_l,
  input  logic             run,
  input  logic             ratio_valid,
  input  logic [7:0]       ratio_data,
  output logic             ratio_ready,
  output logic             ratio_err,
  output logic             clk,
  output logic             clk_rise,
  output logic [CNT_W-1:0] slow_count
);

  localparam logic [7:0] c_default_n = 8'(DEFAULT_RATIO);

  // S_ARM spends the first edge after reset release doing nothing.
  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_IDLE = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] n_q, n_d;
  logic [7:0] pend_n_q, pend_n_d;
  logic       pend_q, pend_d;
  logic       clk_q, clk_d;
  logic       rise_q, rise_d;
  logic       err_q, err_d;
  logic       w_accept;
  logic       w_apply;
  logic [7:0] w_half;

  assign w_accept = ratio_valid && !pend_q;
  assign w_half   = {1'b0, n_q[7:1]};

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    n_d      = n_q;
    pend_d   = pend_q;
    pend_n_d = pend_n_q;
    clk_d    = 1'b0;
    rise_d   = 1'b0;
    w_apply  = 1'b0;

    unique case (state_q)
      S_ARM: begin
        state_d = S_IDLE;
      end
      S_IDLE: begin
        phase_d = 8'd0;
        w_apply = pend_q;
        if (run) begin
          state_d = S_RUN;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
          phase_d = 8'd0;
          w_apply = pend_q;
        end else if (phase_q == n_q - 8'd1) begin
          phase_d = 8'd0;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
          w_apply = pend_q;
        end else begin
          phase_d = phase_q + 8'd1;
          clk_d   = (phase_q + 8'd1) < w_half;
        end
      end
      default: begin
        state_d = S_ARM;
      end
    endcase

    // A ratio accepted now cannot collide with w_apply: acceptance needs !pend_q.
    if (w_apply) begin
      n_d    = pend_n_q;
      pend_d = 1'b0;
    end
    if (w_accept && (ratio_data >= 8'd2)) begin
      pend_d   = 1'b1;
      pend_n_d = ratio_data;
    end
    err_d = w_accept && (ratio_data < 8'd2);
  end

  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= S_ARM;
      phase_q  <= 8'd0;
      n_q      <= c_default_n;
      pend_q   <= 1'b0;
      pend_n_q <= 8'd0;
      clk_q    <= 1'b0;
      rise_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      n_q      <= n_d;
      pend_q   <= pend_d;
      pend_n_q <= pend_n_d;
      clk_q    <= clk_d;
      rise_q   <= rise_d;
      err_q    <= err_d;
    end
  end

  assign ratio_ready = !pend_q;
  assign ratio_err   = err_q;
  assign clk         = clk_q;
  assign clk_rise    = rise_q;

`ifdef CLK_RATIO_GEN_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts in step with clk_rise so both change on the same edge; saturates.
  always_ff @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q <= '0;
    end else if (rise_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign slow_count = cnt_q;
`else
  assign slow_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clk_ratio_gen.sv
// ============================================================================
// Module   : tb_clk_ratio_gen
// Brief    : Self-checking bench for clk_ratio_gen: period-level reference
//            model, directed scenarios with literal expectations, random phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_ratio_gen;

  localparam int TB_CNT_W = 8;
`ifdef CLK_RATIO_GEN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                fastclk;
  logic                reset_l;
  logic                run;
  logic                ratio_valid;
  logic [7:0]          ratio_data;
  logic                ratio_ready;
  logic                ratio_err;
  logic                clk;
  logic                clk_rise;
  logic [TB_CNT_W-1:0] slow_count;

  clk_ratio_gen #(.DEFAULT_RATIO(4), .CNT_W(TB_CNT_W)) dut (
    .fastclk     (fastclk),
    .reset_l     (reset_l),
    .run         (run),
    .ratio_valid (ratio_valid),
    .ratio_data  (ratio_data),
    .ratio_ready (ratio_ready),
    .ratio_err   (ratio_err),
    .clk         (clk),
    .clk_rise    (clk_rise),
    .slow_count  (slow_count)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int errs     = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: position within the current period, active N, pending slot.
  int  m_pos, m_n, m_pn, m_cnt;
  bit  m_started, m_armed, m_pend, m_clk, m_rise, m_err;

  always @(posedge fastclk or negedge reset_l) begin
    if (!reset_l) begin
      m_pos = 0; m_n = 4; m_pn = 0; m_cnt = 0;
      m_started = 0; m_armed = 0; m_pend = 0;
      m_clk = 0; m_rise = 0; m_err = 0;
    end else begin
      bit acc;
      int d;
      acc = ratio_valid && !m_pend;
      d = int'(ratio_data);
      m_rise = 0;
      if (!(run && m_armed)) begin
        m_started = 0;
        m_pos = 0;
        if (m_pend) begin m_n = m_pn; m_pend = 0; end
      end else begin
        if (!m_started) begin m_started = 1; m_pos = 0; end
        else m_pos = (m_pos + 1) % m_n;
        if (m_pos == 0) begin
          m_rise = 1;
          if (m_pend) begin m_n = m_pn; m_pend = 0; end
        end
      end
      m_clk = m_started && (m_pos < m_n / 2);
      m_err = acc && (d < 2);
      if (acc && d >= 2) begin m_pend = 1; m_pn = d; end
      m_armed = 1;
      if (m_rise && m_cnt < (1 << TB_CNT_W) - 1) m_cnt++;
    end
  end

  always @(negedge fastclk) begin
    if (reset_l && chk_en) begin
      check("clk",         clk,         m_clk);
      check("clk_rise",    clk_rise,    m_rise);
      check("ratio_ready", ratio_ready, !m_pend);
      check("ratio_err",   ratio_err,   m_err);
      check("slow_count",  slow_count,  STATS ? m_cnt : 0);
    end
    if (reset_l && ratio_err) errs++;
  end

  task automatic wait_rise(input int budget);
    int k;
    k = 0;
    @(negedge fastclk);
    while (!clk_rise && k < budget) begin @(negedge fastclk); k++; end
    if (!clk_rise) check("wait_rise_timeout", 0, 1);
  endtask

  task automatic measure_period(output int p);
    p = 0;
    do begin @(negedge fastclk); p++; end while (!clk_rise && p < 300);
  endtask

  task automatic send(input int v);
    int k;
    ratio_valid = 1'b1;
    ratio_data  = 8'(v);
    k = 0;
    while (!ratio_ready && k < 300) begin @(negedge fastclk); k++; end
    if (!ratio_ready) check("send_timeout", 0, 1);
    @(negedge fastclk);
    ratio_valid = 1'b0;
  endtask

  initial begin
    int pat, hi, p, e0, k;
    bit rdy_prev;
    run = 0; ratio_valid = 0; ratio_data = 0; reset_l = 0;
    #12;
    check("rst_clk", clk, 0);
    check("rst_rise", clk_rise, 0);
    check("rst_err", ratio_err, 0);
    check("rst_ready", ratio_ready, 1);
    check("rst_count", slow_count, 0);
    @(negedge fastclk);
    reset_l = 1; chk_en = 1; run = 1;

    // Default N=4: 1,1,0,0 repeating, ten rises in the first 40 cycles.
    wait_rise(10);
    pat = 0;
    for (int i = 0; i < 8; i++) begin
      pat = (pat << 1) | int'(clk);
      @(negedge fastclk);
    end
    check("pattern_n4", pat, 8'b11001100);
    repeat (31) @(negedge fastclk);
    check("count_40", slow_count, STATS ? 10 : 0);

    // Ratio 7 mid-period: ready low until wrap, then period 7 / high 3.
    repeat (2) @(negedge fastclk);
    send(7);
    check("ready_low_pending", ratio_ready, 0);
    wait_rise(10);
    check("ready_after_wrap", ratio_ready, 1);
    hi = 0;
    for (int i = 0; i < 7; i++) begin hi += int'(clk); @(negedge fastclk); end
    check("high_n7", hi, 3);
    check("period_n7", clk_rise, 1);

    // Back to 4, then illegal ratios 1 and 0.
    send(4);
    wait_rise(20);
    e0 = errs;
    send(1);
    send(0);
    repeat (3) @(negedge fastclk);
    check("err_pulses", errs - e0, 2);
    wait_rise(20);
    measure_period(p);
    check("period_after_err", p, 4);

    // Ratio 6 offered on the exact wrap edge.
    k = 0;
    @(negedge fastclk);
    while (!(m_started && m_pos == m_n - 1) && k < 20) begin @(negedge fastclk); k++; end
    ratio_valid = 1; ratio_data = 8'd6;
    @(negedge fastclk);
    ratio_valid = 0;
    check("wrap_accept_rise", clk_rise, 1);
    measure_period(p);
    check("period_old_4", p, 4);
    measure_period(p);
    check("period_new_6", p, 6);

    // Drop run at phase 1 with ratio 3 pending.
    ratio_valid = 1; ratio_data = 8'd3;
    @(negedge fastclk);
    ratio_valid = 0;
    run = 0;
    @(negedge fastclk);
    check("idle_clk", clk, 0);
    check("idle_applied", ratio_ready, 1);
    run = 1;
    wait_rise(10);
    pat = 0;
    for (int i = 0; i < 6; i++) begin
      pat = (pat << 1) | int'(clk);
      @(negedge fastclk);
    end
    check("pattern_n3", pat, 6'b100100);

    // Asynchronous reset between edges at phase 2.
    wait_rise(10);
    repeat (2) @(negedge fastclk);
    #2 reset_l = 0;
    #1;
    check("async_clk", clk, 0);
    check("async_rise", clk_rise, 0);
    check("async_count", slow_count, 0);
    @(negedge fastclk);
    reset_l = 1;

    // Random phase.
    rdy_prev = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge fastclk);
      if ($urandom_range(0, 39) == 0) run = ~run;
      if (ratio_valid && rdy_prev) ratio_valid = 0;
      if (!ratio_valid && $urandom_range(0, 7) == 0) begin
        int r;
        r = int'($urandom_range(0, 15));
        ratio_valid = 1;
        if (r < 13)       ratio_data = 8'(r);
        else if (r == 13) ratio_data = 8'd255;
        else              ratio_data = 8'($urandom_range(2, 40));
      end
      rdy_prev = ratio_ready;
      if ($urandom_range(0, 599) == 0) begin
        #3 reset_l = 0;
        #1 check("rand_async_clk", clk, 0);
        @(negedge fastclk);
        reset_l = 1;
        ratio_valid = 0;
        rdy_prev = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
